fir_out_decimator: RTL and testbench

Downstream stage of the FIR low-pass filter. Takes the filter's continuous yn stream, discards the filter warm-up samples, keeps every DECIM-th sample, and buffers the kept samples in a small FIFO. The FIFO is read through a valid/ready handshake by the next stage, for example a UART or memory writer. Records a sticky overflow flag when a kept sample cannot be stored.

---
 rtl/fir_pkg.sv | 25 ++
 rtl/fir_sync_fifo.sv | 54 +++++
 rtl/fir_out_decimator.sv | 107 ++++++++++
 tb/tb_fir_out_decimator.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR output decimator and its FIFO.
package fir_pkg;

    localparam int DATA_W_DEF     = 8;
    localparam int FIFO_DEPTH_DEF = 8;

    // Decimator phase of life: discarding filter warm-up, or producing output.
    typedef enum logic {
        WARMUP = 1'b0,
        RUN    = 1'b1
    } dec_state_e;

    // Address width for a FIFO of the given depth (at least one bit).
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Width of a counter that must reach the value n (at least one bit).
    function automatic int cnt_w(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

    localparam int FIFO_AW_DEF = addr_w(FIFO_DEPTH_DEF);

endpackage

// File: rtl/fir_sync_fifo.sv
// First-word-fall-through FIFO: the head entry is always visible on rd_data.
// A write while full is accepted only when the head is popped in the same cycle.
module fir_sync_fifo
    import fir_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int DEPTH  = FIFO_DEPTH_DEF,
    localparam int AW     = addr_w(DEPTH),
    localparam int LW     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              push,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [LW-1:0]     level,
    output logic              full
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              pop;
    logic              wr_en;

    assign rd_valid = (level != '0);
    assign full     = (level == LW'(DEPTH));
    assign rd_data  = mem[rd_ptr];
    assign pop      = rd_valid && rd_ready;
    // Full is fine if the head leaves this cycle: the slot being freed is the one written.
    assign wr_en    = push && (!full || pop);

    // Storage array; contents need no reset since out_valid gates them.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    // Pointers wrap naturally; occupancy is tracked separately in level.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            if (wr_en && !pop)      level <= level + 1'b1;
            else if (pop && !wr_en) level <= level - 1'b1;
        end
    end

endmodule

// File: rtl/fir_out_decimator.sv
// FIR output decimator: drops SKIP warm-up samples, keeps every DECIM-th
// sample afterwards and buffers it in a FWFT FIFO with a sticky overflow flag.
// Optional: define FIR_DECIM_DROP_CNT_EN to add a saturating drop counter.
module fir_out_decimator
    import fir_pkg::*;
#(
    parameter  int DATA_W     = DATA_W_DEF,
    parameter  int DECIM      = 4,
    parameter  int SKIP       = 16,
    parameter  int FIFO_DEPTH = FIFO_DEPTH_DEF,
    localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [DATA_W-1:0] yn,
    input  logic              yn_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LW-1:0]     level,
    output logic              ovf,
    input  logic              ovf_clr
`ifdef FIR_DECIM_DROP_CNT_EN
    ,
    output logic [7:0]        drop_cnt
`endif
);

    localparam int SKIP_W = cnt_w(SKIP);
    localparam int PH_W   = addr_w(DECIM);
    localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'((SKIP > 0) ? SKIP - 1 : 0);
    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(DECIM - 1);
    // With no warm-up the decimator comes out of reset already producing.
    localparam dec_state_e RST_STATE = (SKIP == 0) ? RUN : WARMUP;

    dec_state_e        state;
    dec_state_e        state_nxt;
    logic [SKIP_W-1:0] skip_cnt;
    logic [PH_W-1:0]   phase;
    logic              keep;
    logic              fifo_full;
    logic              pop;
    logic              drop;

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= RST_STATE;
        else        state <= state_nxt;
    end

    // Next state and keep decision; only a valid sample moves anything.
    always_comb begin
        state_nxt = state;
        keep      = 1'b0;
        case (state)
            WARMUP: if (yn_valid && skip_cnt == SKIP_LAST) state_nxt = RUN;
            RUN:    keep = yn_valid && (phase == '0);
        endcase
    end

    // Warm-up sample counter.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)                          skip_cnt <= '0;
        else if (state == WARMUP && yn_valid) skip_cnt <= skip_cnt + 1'b1;
    end

    // Decimation phase; phase 0 marks the sample to keep.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)                       phase <= '0;
        else if (state == RUN && yn_valid) phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
    end

    assign pop  = out_valid && out_ready;
    assign drop = keep && fifo_full && !pop;

    fir_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .n_rst    (n_rst),
        .push     (keep),
        .wr_data  (yn),
        .rd_ready (out_ready),
        .rd_data  (out_data),
        .rd_valid (out_valid),
        .level    (level),
        .full     (fifo_full)
    );

    // Sticky overflow; a drop in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)       ovf <= 1'b0;
        else if (drop)    ovf <= 1'b1;
        else if (ovf_clr) ovf <= 1'b0;
    end

`ifdef FIR_DECIM_DROP_CNT_EN
    // Saturating count of dropped kept samples; a clear with a drop leaves 1.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)                       drop_cnt <= '0;
        else if (ovf_clr)                 drop_cnt <= {7'd0, drop};
        else if (drop && drop_cnt != '1)  drop_cnt <= drop_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_fir_out_decimator.sv
// Bench for fir_out_decimator: a table-driven check of a DECIM=1/SKIP=0 instance
// and model-checked directed and random streams on the default instance.
module tb_fir_out_decimator;

    localparam int DW  = 8;
    localparam int DEC = 4;
    localparam int SK  = 16;
    localparam int DEP = 8;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;

    // default instance
    logic [DW-1:0] yn = '0;
    logic          yn_valid = 1'b0, out_ready = 1'b0, ovf_clr = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_valid, ovf;
    logic [3:0]    level;
    // DECIM=1, SKIP=0, depth 4 instance
    logic [DW-1:0] t_yn = '0;
    logic          t_valid = 1'b0, t_ready = 1'b0, t_clr = 1'b0;
    logic [DW-1:0] t_data;
    logic          t_ovalid, t_ovf;
    logic [2:0]    t_level;
`ifdef FIR_DECIM_DROP_CNT_EN
    logic [7:0]    dc0, dc1;
`endif

    always #5 clk = ~clk;

    fir_out_decimator #(.DATA_W(DW), .DECIM(DEC), .SKIP(SK), .FIFO_DEPTH(DEP)) u_dut (
        .clk(clk), .n_rst(n_rst), .yn(yn), .yn_valid(yn_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .level(level), .ovf(ovf), .ovf_clr(ovf_clr)
`ifdef FIR_DECIM_DROP_CNT_EN
        , .drop_cnt(dc0)
`endif
    );

    fir_out_decimator #(.DATA_W(DW), .DECIM(1), .SKIP(0), .FIFO_DEPTH(4)) u_dut1 (
        .clk(clk), .n_rst(n_rst), .yn(t_yn), .yn_valid(t_valid),
        .out_data(t_data), .out_valid(t_ovalid), .out_ready(t_ready),
        .level(t_level), .ovf(t_ovf), .ovf_clr(t_clr)
`ifdef FIR_DECIM_DROP_CNT_EN
        , .drop_cnt(dc1)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // ---------------- behavioural reference (default instance) -------------
    int             m_vcnt;   // valid samples seen since reset
    logic [DW-1:0]  m_q[$];
    bit             m_ovf;
    int             m_dc;

    function automatic bit m_keeps();
        return (m_vcnt >= SK) && (((m_vcnt - SK) % DEC) == 0);
    endfunction

    function automatic void model_reset();
        m_vcnt = 0;
        m_q.delete();
        m_ovf = 0;
        m_dc = 0;
    endfunction

    function automatic void model_step(input bit v, input bit rdy, input bit clr, input logic [DW-1:0] d);
        bit pop, keep, drop;
        pop  = (m_q.size() != 0) && rdy;
        keep = v && m_keeps();
        drop = 0;
        if (v) m_vcnt++;
        if (pop) void'(m_q.pop_front());
        if (keep) begin
            if (m_q.size() < DEP) m_q.push_back(d);
            else drop = 1;
        end
        if (drop)     m_ovf = 1;
        else if (clr) m_ovf = 0;
        if (clr)                      m_dc = drop ? 1 : 0;
        else if (drop && m_dc < 255)  m_dc++;
    endfunction

    task automatic check_all();
        chk("out_valid", out_valid, m_q.size() != 0);
        chk("level", level, m_q.size());
        chk("ovf", ovf, m_ovf);
        if (m_q.size() != 0) chk("out_data", out_data, m_q[0]);
`ifdef FIR_DECIM_DROP_CNT_EN
        chk("drop_cnt", dc0, m_dc);
`endif
    endtask

    // One clock: model sees the same inputs the DUT samples, compare after the edge.
    task automatic step();
        @(posedge clk);
        model_step(yn_valid, out_ready, ovf_clr, yn);
        #1;
        check_all();
    endtask

    int ramp;
    task automatic ramp_step(input bit v, input bit rdy);
        yn_valid = v;
        out_ready = rdy;
        yn = ramp[DW-1:0];
        step();
        if (v) ramp++;
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        yn_valid = 0; out_ready = 0; ovf_clr = 0; yn = '0;
        t_valid = 0; t_ready = 0; t_clr = 0; t_yn = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        model_reset();
        ramp = 0;
    endtask

    // ---------------- table for the DECIM=1 / SKIP=0 instance --------------
    typedef struct {
        logic          v, rdy, clr;
        logic [DW-1:0] d;
        logic          e_valid;
        logic [DW-1:0] e_data;
        int            e_level;
        logic          e_ovf;
        int            e_dc;
    } vec_t;
    vec_t tbl[16];

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        logic [DW-1:0] first;

        tbl[0]  = '{1, 0, 0, 8'hA1, 1, 8'hA1, 1, 0, 0};
        tbl[1]  = '{1, 0, 0, 8'hB2, 1, 8'hA1, 2, 0, 0};
        tbl[2]  = '{0, 1, 0, 8'hC3, 1, 8'hB2, 1, 0, 0};
        tbl[3]  = '{1, 1, 0, 8'hD4, 1, 8'hD4, 1, 0, 0};
        tbl[4]  = '{1, 0, 0, 8'hE5, 1, 8'hD4, 2, 0, 0};
        tbl[5]  = '{1, 0, 0, 8'hF6, 1, 8'hD4, 3, 0, 0};
        tbl[6]  = '{1, 0, 0, 8'h07, 1, 8'hD4, 4, 0, 0};
        tbl[7]  = '{1, 0, 0, 8'h18, 1, 8'hD4, 4, 1, 1};
        tbl[8]  = '{1, 1, 0, 8'h29, 1, 8'hE5, 4, 1, 1};
        tbl[9]  = '{0, 0, 1, 8'h3A, 1, 8'hE5, 4, 0, 0};
        tbl[10] = '{0, 1, 0, 8'h00, 1, 8'hF6, 3, 0, 0};
        tbl[11] = '{0, 1, 0, 8'h00, 1, 8'h07, 2, 0, 0};
        tbl[12] = '{0, 1, 0, 8'h00, 1, 8'h29, 1, 0, 0};
        tbl[13] = '{0, 1, 0, 8'h00, 0, 8'h00, 0, 0, 0};
        tbl[14] = '{1, 1, 0, 8'h5B, 1, 8'h5B, 1, 0, 0};
        tbl[15] = '{0, 1, 0, 8'h00, 0, 8'h00, 0, 0, 0};

        // reset state, checked while reset is held
        n_rst = 1'b0;
        #7;
        chk("rst_valid", out_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst1_level", t_level, 0);
        do_reset();

        // DECIM=1 SKIP=0: first sample after reset is kept
        foreach (tbl[i]) begin
            t_valid = tbl[i].v; t_ready = tbl[i].rdy; t_clr = tbl[i].clr; t_yn = tbl[i].d;
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_valid", i), t_ovalid, tbl[i].e_valid);
            chk($sformatf("tbl%0d_level", i), t_level, tbl[i].e_level);
            chk($sformatf("tbl%0d_ovf", i), t_ovf, tbl[i].e_ovf);
            if (tbl[i].e_valid) chk($sformatf("tbl%0d_data", i), t_data, tbl[i].e_data);
`ifdef FIR_DECIM_DROP_CNT_EN
            chk($sformatf("tbl%0d_dc", i), dc1, tbl[i].e_dc);
`endif
        end

        // free-running ramp, consumer always ready
        do_reset();
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            ramp_step(1, 1);
            chk("ramp_lvl_le1", level <= 1, 1);
            if (!seen && out_valid) begin
                seen = 1;
                chk("ramp_first", out_data, 8'h10);
                chk("ramp_first_cyc", i, 16);
            end
        end
        chk("ramp_seen", seen, 1);

        // same ramp with a gap every other cycle
        do_reset();
        seen = 0;
        for (int i = 0; i < 120; i++) begin
            ramp_step(i % 2 == 0, 1);
            if (!seen && out_valid) begin
                seen = 1;
                chk("gap_first", out_data, 8'h10);
            end
        end
        chk("gap_seen", seen, 1);

        // back-pressure after warm-up: fill, overflow, drain
        do_reset();
        for (int i = 0; i < SK; i++) ramp_step(1, 1);
        for (int i = 0; i < 60; i++) ramp_step(1, 0);
        chk("fill_level", level, 8);
        chk("fill_ovf", ovf, 1);
        for (int i = 0; i < 8; i++) begin
            chk("drain_data", out_data, 8'h10 + 4 * i);
            ramp_step(0, 1);
        end
        chk("drain_level", level, 0);

        // clear, refill, then kept samples meet a pop while full
        ovf_clr = 1; ramp_step(0, 0); ovf_clr = 0;
        chk("clr_ovf", ovf, 0);
        for (int i = 0; i < 100 && m_q.size() < DEP; i++) ramp_step(1, 0);
        chk("refill_level", level, 8);
        for (int i = 0; i < 12; i++) ramp_step(1, m_keeps());
        chk("fullpop_level", level, 8);
        chk("fullpop_ovf", ovf, 0);
        ovf_clr = 1; ramp_step(0, 0); ovf_clr = 0;
        chk("clr2_ovf", ovf, 0);

        // asynchronous reset mid-stream with five entries buffered
        do_reset();
        for (int i = 0; i < 100 && m_q.size() < 5; i++) ramp_step(1, 0);
        chk("pre_rst_level", level, 5);
        #2;
        n_rst = 1'b0;
        #1;
        chk("async_level", level, 0);
        chk("async_valid", out_valid, 0);
        model_reset();
        @(negedge clk);
        n_rst = 1'b1;
        first = DW'(ramp + SK);
        for (int i = 0; i < SK + 1; i++) ramp_step(1, 0);
        chk("rst_first_valid", out_valid, 1);
        chk("rst_first_data", out_data, first);

        // random traffic against the model
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            yn_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) == 0);
            ovf_clr   = ($urandom_range(0, 15) == 0);
            yn        = DW'($urandom);
            step();
        end
        ovf_clr = 0;

        // long stall: hundreds of drops
        do_reset();
        for (int i = 0; i < SK + 300 * DEC; i++) ramp_step(1, 0);
        chk("sat_ovf", ovf, 1);
`ifdef FIR_DECIM_DROP_CNT_EN
        chk("sat_drop_cnt", dc0, 255);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
